// File: rtl/soft_error_pkg.sv
// rtl/soft_error_pkg.sv - shared types, defaults and width helpers for the soft-error monitor
package soft_error_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_ARMED = 1'b1
  } sem_state_t;

  localparam logic [15:0] DEFAULT_PATTERN = 16'hA5C3;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/soft_error_cell.sv
// rtl/soft_error_cell.sv - one channel: redundant banks A/B, compare, scrub, saturating counters, pulses
module soft_error_cell
  import soft_error_pkg::*;
#(
  parameter int                BANK_W  = 16,
  parameter logic [BANK_W-1:0] PATTERN = BANK_W'(DEFAULT_PATTERN),
  parameter int                CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  armed,
  input  logic [1:0]            inj,
  input  logic [BANK_W-1:0]     inj_mask,
  output logic [1:0]            event_hit,
  output logic [1:0]            pulse,
  output logic [1:0][CNT_W-1:0] cnt
);

  // Index 0 is bank A, index 1 is bank B; kept distinct so they are never merged or constant-folded.
  (* keep = "true", dont_touch = "true" *) logic [BANK_W-1:0] bank [2];
  (* keep = "true", dont_touch = "true" *) logic [1:0]        mismatch;

  always_comb begin
    mismatch = '0;
    for (int b = 0; b < 2; b++) begin
      mismatch[b] = (bank[b] != PATTERN);
    end
    event_hit = mismatch & {2{armed}};
  end

  // Scrub has priority over a same-edge injection, so that injection is lost.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        bank[b]  <= PATTERN;
        cnt[b]   <= '0;
        pulse[b] <= 1'b0;
      end else begin
        if (mismatch[b]) begin
          bank[b] <= PATTERN;
        end else if (inj[b]) begin
          bank[b] <= bank[b] ^ inj_mask;
        end
        pulse[b] <= event_hit[b];
        if (clr) begin
          cnt[b] <= CNT_W'(event_hit[b]);
        end else if (event_hit[b] && (cnt[b] != '1)) begin
          cnt[b] <= cnt[b] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/soft_error_monitor_array.sv
// rtl/soft_error_monitor_array.sv - N_CH-channel upset sensor array with arming FSM, injection and readout
module soft_error_monitor_array
  import soft_error_pkg::*;
#(
  parameter int                N_CH     = 8,
  parameter int                BANK_W   = 16,
  parameter logic [BANK_W-1:0] PATTERN  = BANK_W'(DEFAULT_PATTERN),
  parameter int                CNT_W    = 16,
  parameter int                INIT_CYC = 32,
  parameter string             ORIGIN   = "X0Y0",
  localparam int               CH_W     = clog2_min1(N_CH),
  localparam int               BIT_W    = clog2_min1(BANK_W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inj_en,
  input  logic             i_inj_bank,
  input  logic [CH_W-1:0]  i_inj_ch,
  input  logic [BIT_W-1:0] i_inj_bit,
  input  logic [CH_W-1:0]  i_rd_ch,
  output logic [CNT_W-1:0] o_rd_cnt_a,
  output logic [CNT_W-1:0] o_rd_cnt_b,
  output logic [N_CH-1:0]  o_pulse_a,
  output logic [N_CH-1:0]  o_pulse_b,
  output logic             o_armed,
  output logic             error_A,
  output logic             error_B
);

  localparam int               IC_W       = clog2_min1(INIT_CYC);
  localparam logic [CH_W:0]    N_CH_LIM   = N_CH[CH_W:0];
  localparam logic [BIT_W:0]   BANK_W_LIM = BANK_W[BIT_W:0];

  sem_state_t              state;
  logic [IC_W-1:0]         init_cnt;
  logic                    inj_hit;
  logic                    rd_ok;
  logic [BANK_W-1:0]       inj_mask;
  logic [1:0]              ev [N_CH];
  logic [1:0]              pulse [N_CH];
  logic [1:0][CNT_W-1:0]   cnt [N_CH];
  logic                    any_a;
  logic                    any_b;

  assign inj_hit  = i_inj_en && ({1'b0, i_inj_ch} < N_CH_LIM) && ({1'b0, i_inj_bit} < BANK_W_LIM);
  assign inj_mask = BANK_W'(1) << i_inj_bit;
  assign rd_ok    = ({1'b0, i_rd_ch} < N_CH_LIM);
  assign o_armed  = (state == ST_ARMED);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == IC_W'(INIT_CYC - 1)) begin
        state <= ST_ARMED;
      end else begin
        init_cnt <= init_cnt + IC_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0] inj_i;
    assign inj_i = {inj_hit && (i_inj_ch == CH_W'(i)) &&  i_inj_bank,
                    inj_hit && (i_inj_ch == CH_W'(i)) && !i_inj_bank};

    (* rloc_origin = ORIGIN *)
    soft_error_cell #(
      .BANK_W  (BANK_W),
      .PATTERN (PATTERN),
      .CNT_W   (CNT_W)
    ) u_cell (
      .clk       (i_clk),
      .rst       (i_rst),
      .clr       (i_clr),
      .armed     (o_armed),
      .inj       (inj_i),
      .inj_mask  (inj_mask),
      .event_hit (ev[i]),
      .pulse     (pulse[i]),
      .cnt       (cnt[i])
    );

    assign o_pulse_a[i] = pulse[i][0];
    assign o_pulse_b[i] = pulse[i][1];
  end

  always_comb begin
    any_a = 1'b0;
    any_b = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      any_a = any_a | ev[i][0];
      any_b = any_b | ev[i][1];
    end
  end

  // A new event in the clear cycle still leaves the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      error_A    <= 1'b0;
      error_B    <= 1'b0;
      o_rd_cnt_a <= '0;
      o_rd_cnt_b <= '0;
    end else begin
      error_A    <= any_a | (error_A & ~i_clr);
      error_B    <= any_b | (error_B & ~i_clr);
      o_rd_cnt_a <= rd_ok ? cnt[i_rd_ch][0] : '0;
      o_rd_cnt_b <= rd_ok ? cnt[i_rd_ch][1] : '0;
    end
  end

endmodule

// File: tb/tb_soft_error_monitor_array.sv
// tb/tb_soft_error_monitor_array.sv - scoreboard bench for soft_error_monitor_array
module tb_soft_error_monitor_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr1 = 1'b0, clr2 = 1'b0;
  logic       inj_en1 = 1'b0, inj_en2 = 1'b0;
  logic       inj_bank = 1'b0;
  logic [2:0] inj_ch = '0;
  logic [3:0] inj_bit = '0;
  logic [2:0] rd_ch = '0;

  logic [15:0] rd_a1, rd_b1;
  logic [7:0]  pa1, pb1;
  logic        armed1, ea1, eb1;
  logic [3:0]  rd_a2, rd_b2;
  logic [5:0]  pa2, pb2;
  logic        armed2, ea2, eb2;

  soft_error_monitor_array dut1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr1), .i_inj_en(inj_en1), .i_inj_bank(inj_bank),
    .i_inj_ch(inj_ch), .i_inj_bit(inj_bit), .i_rd_ch(rd_ch),
    .o_rd_cnt_a(rd_a1), .o_rd_cnt_b(rd_b1), .o_pulse_a(pa1), .o_pulse_b(pb1),
    .o_armed(armed1), .error_A(ea1), .error_B(eb1)
  );

  soft_error_monitor_array #(.N_CH(6), .CNT_W(4), .INIT_CYC(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr2), .i_inj_en(inj_en2), .i_inj_bank(inj_bank),
    .i_inj_ch(inj_ch), .i_inj_bit(inj_bit), .i_rd_ch(rd_ch),
    .o_rd_cnt_a(rd_a2), .o_rd_cnt_b(rd_b2), .o_pulse_a(pa2), .o_pulse_b(pb2),
    .o_armed(armed2), .error_A(ea2), .error_B(eb2)
  );

  always #5 clk = ~clk;

  localparam int K_PA1 = 0, K_PB1 = 1, K_RA1 = 2, K_RB1 = 3, K_EA1 = 4, K_EB1 = 5, K_AR1 = 6;
  localparam int K_PA2 = 10, K_RA2 = 12, K_EA2 = 14, K_AR2 = 16;

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [63:0] sample(input int kind);
    case (kind)
      K_PA1:   return 64'(pa1);
      K_PB1:   return 64'(pb1);
      K_RA1:   return 64'(rd_a1);
      K_RB1:   return 64'(rd_b1);
      K_EA1:   return 64'(ea1);
      K_EB1:   return 64'(eb1);
      K_AR1:   return 64'(armed1);
      K_PA2:   return 64'(pa2);
      K_RA2:   return 64'(rd_a2);
      K_EA2:   return 64'(ea2);
      K_AR2:   return 64'(armed2);
      default: return 64'hdead;
    endcase
  endfunction

  // Expected value for an output, due lat rising edges from now.
  task automatic expect_at(input int lat, input int kind, input logic [63:0] v, input string tag);
    exp_t e;
    e.due  = cycle + lat;
    e.kind = kind;
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cycle) check(sb[i].tag, sample(sb[i].kind), sb[i].val);
      else if (sb[i].due < cycle) check({sb[i].tag, "_late"}, 64'd1, 64'd0);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic inject(input int dut, input int ch, input int bank, input int b);
    inj_ch   = ch[2:0];
    inj_bank = bank[0];
    inj_bit  = b[3:0];
    if (dut == 1) inj_en1 = 1'b1;
    else          inj_en2 = 1'b1;
    tick(1);
    inj_en1 = 1'b0;
    inj_en2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    expect_at(0, K_AR1, 0, "rst_armed1");
    expect_at(0, K_EA1, 0, "rst_err_a1");
    expect_at(0, K_EB1, 0, "rst_err_b1");
    expect_at(0, K_RA1, 0, "rst_rd_a1");
    expect_at(0, K_PA1, 0, "rst_pulse_a1");
    expect_at(0, K_AR2, 0, "rst_armed2");
    tick(1);

    // Arming boundary and injection while still in INIT.
    rst = 1'b0;
    expect_at(31, K_AR1, 0, "init_armed1_31");
    expect_at(32, K_AR1, 1, "init_armed1_32");
    expect_at(3, K_AR2, 0, "init_armed2_3");
    expect_at(4, K_AR2, 1, "init_armed2_4");
    expect_at(2, K_PA1, 0, "init_inj_no_pulse");
    expect_at(2, K_EA1, 0, "init_inj_no_flag");
    inject(1, 1, 0, 2);
    tick(33);
    rd_ch = 3'd1;
    expect_at(1, K_RA1, 0, "init_inj_cnt");
    tick(2);

    // Single A event on ch3.
    expect_at(2, K_PA1, 64'h08, "ch3_pulse");
    expect_at(3, K_PA1, 64'h00, "ch3_pulse_width");
    expect_at(2, K_PB1, 64'h00, "ch3_no_pulse_b");
    expect_at(2, K_EA1, 1, "ch3_err_a");
    expect_at(2, K_EB1, 0, "ch3_no_err_b");
    inject(1, 3, 0, 5);
    tick(2);
    rd_ch = 3'd3;
    expect_at(1, K_RA1, 1, "ch3_cnt_a");
    expect_at(1, K_RB1, 0, "ch3_cnt_b");
    tick(2);

    // A then B on ch2, one cycle apart.
    expect_at(2, K_PA1, 64'h04, "ch2_pulse_a");
    inject(1, 2, 0, 0);
    expect_at(2, K_PB1, 64'h04, "ch2_pulse_b");
    expect_at(2, K_PA1, 64'h00, "ch2_pulse_a_gone");
    inject(1, 2, 1, 15);
    tick(2);
    rd_ch = 3'd2;
    expect_at(1, K_RA1, 1, "ch2_cnt_a");
    expect_at(1, K_RB1, 1, "ch2_cnt_b");
    expect_at(1, K_EA1, 1, "ch2_err_a");
    expect_at(1, K_EB1, 1, "ch2_err_b");
    tick(2);

    // Back-to-back injection: the second lands on the scrub edge and is lost.
    expect_at(2, K_PA1, 64'h10, "scrub_pulse");
    expect_at(3, K_PA1, 64'h00, "scrub_no_second");
    inject(1, 4, 0, 1);
    inject(1, 4, 0, 2);
    tick(3);
    rd_ch = 3'd4;
    expect_at(1, K_RA1, 1, "scrub_cnt");
    tick(2);

    // Out-of-range channel on the 6-channel instance.
    expect_at(2, K_PA2, 0, "oor_no_pulse");
    expect_at(2, K_EA2, 0, "oor_no_flag");
    inject(2, 6, 0, 3);
    tick(2);
    rd_ch = 3'd6;
    expect_at(1, K_RA2, 0, "oor_read");
    tick(1);
    rd_ch = 3'd0;
    expect_at(1, K_RA2, 0, "oor_ch0_clean");
    tick(2);

    // Saturation at 15 with a 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      expect_at(2, K_PA2, 64'h01, $sformatf("sat_pulse_%0d", k));
      inject(2, 0, 0, k % 16);
      tick(1);
    end
    tick(2);
    expect_at(1, K_RA2, 15, "sat_cnt");
    expect_at(1, K_EA2, 1, "sat_err");
    tick(2);

    // Plain clear.
    clr2 = 1'b1;
    expect_at(1, K_EA2, 0, "clr_err");
    tick(1);
    clr2 = 1'b0;
    tick(1);
    expect_at(1, K_RA2, 0, "clr_cnt");
    tick(2);

    // Clear coinciding with an event.
    expect_at(2, K_PA2, 64'h01, "clr_ev_pulse");
    inject(2, 0, 0, 7);
    clr2 = 1'b1;
    tick(1);
    clr2 = 1'b0;
    tick(2);
    expect_at(1, K_RA2, 1, "clr_ev_cnt");
    expect_at(1, K_EA2, 1, "clr_ev_err");
    tick(2);

    // Reset lands on the scrub edge of a pending B event.
    expect_at(2, K_PB1, 0, "rst_mid_no_pulse");
    expect_at(2, K_EB1, 0, "rst_mid_err_b");
    expect_at(2, K_EA1, 0, "rst_mid_err_a");
    expect_at(2, K_AR1, 0, "rst_mid_armed1");
    expect_at(2, K_AR2, 0, "rst_mid_armed2");
    inject(1, 5, 1, 9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_at(31, K_AR1, 0, "rearm_31");
    expect_at(32, K_AR1, 1, "rearm_32");
    tick(3);
    rd_ch = 3'd3;
    expect_at(1, K_RA1, 0, "rst_mid_ch3_cnt");
    tick(2);
    rd_ch = 3'd5;
    expect_at(1, K_RB1, 0, "rst_mid_ch5_cnt");
    tick(32);
    rd_ch = 3'd5;
    expect_at(1, K_RB1, 0, "rst_mid_ch5_armed");
    tick(3);

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
